// File: rtl/interrupt_trap_unit.sv
// interrupt_trap_unit
//   Core-side consumer of the interrupt controller handshake. It accepts a
//   one-cycle request pulse with its handler vector and waits for an
//   instruction boundary with interrupts globally enabled. At that boundary it
//   saves the return PC and cause, redirects fetch to the handler, and holds
//   interrupt_pending until mret retires. On return it redirects fetch back to
//   the saved PC.
//
// Ports
//   clk_in              system clock, rising edge
//   reset_in            asynchronous, active-high reset
//   interrupt_signal    one-cycle request pulse from the controller
//   interrupt_pc_in     handler vector, valid with interrupt_signal
//   retire_valid_in     an instruction retires this cycle (boundary point)
//   retire_pc_next_in   PC of the next instruction, valid with retire_valid_in
//   mret_in             mret retires this cycle
//   csr_mie_in          global machine interrupt enable
//   interrupt_pending   high from acceptance until the return redirect is done
//   pc_redirect_valid   one-cycle fetch redirect strobe
//   pc_redirect_target  redirect address, holds its value between strobes
//   csr_mepc_out        saved return PC
//   csr_mcause_out      saved cause
//   csr_wr_enable       one-cycle strobe when mepc/mcause are updated
//   dropped_count       saturating count of pulses that arrived while busy
module interrupt_trap_unit #(
  parameter logic [63:0] TIMER_VECTOR = 64'h1
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        interrupt_signal,
  input  logic [63:0] interrupt_pc_in,
  input  logic        retire_valid_in,
  input  logic [63:0] retire_pc_next_in,
  input  logic        mret_in,
  input  logic        csr_mie_in,
  output logic        interrupt_pending,
  output logic        pc_redirect_valid,
  output logic [63:0] pc_redirect_target,
  output logic [63:0] csr_mepc_out,
  output logic [63:0] csr_mcause_out,
  output logic        csr_wr_enable,
  output logic [7:0]  dropped_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BOUNDARY,
    S_ENTER,
    S_HANDLER,
    S_EXIT
  } state_t;

  localparam logic [63:0] CAUSE_TIMER = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_EXT   = 64'h8000_0000_0000_000B;

  // Interrupt bit set; code 7 for the timer vector, 11 for anything else.
  function automatic logic [63:0] cause_for(input logic [63:0] vec);
    return (vec == TIMER_VECTOR) ? CAUSE_TIMER : CAUSE_EXT;
  endfunction

  // Count up by one, sticking at the top instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  state_t      state_q, state_d;
  logic [63:0] vector_q, vector_d;
  logic        pending_q, pending_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [63:0] redirect_target_q, redirect_target_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic        wr_enable_q, wr_enable_d;
  logic [7:0]  dropped_q, dropped_d;

  always_comb begin
    state_d           = state_q;
    vector_d          = vector_q;
    mepc_d            = mepc_q;
    mcause_d          = mcause_q;
    redirect_target_d = redirect_target_q;
    dropped_d         = dropped_q;

    case (state_q)
      S_IDLE: begin
        // mret is meaningless here; only a new request moves us on.
        if (interrupt_signal) begin
          vector_d = interrupt_pc_in;
          state_d  = S_WAIT_BOUNDARY;
        end
      end
      S_WAIT_BOUNDARY: begin
        // A retire with interrupts enabled is the only way out; a concurrent
        // mret belongs to no handler of ours and is ignored.
        if (retire_valid_in && csr_mie_in) begin
          mepc_d            = retire_pc_next_in;
          mcause_d          = cause_for(vector_q);
          redirect_target_d = vector_q;
          state_d           = S_ENTER;
        end
      end
      S_ENTER: state_d = S_HANDLER;
      S_HANDLER: begin
        if (mret_in) begin
          redirect_target_d = mepc_q;
          state_d           = S_EXIT;
        end
      end
      S_EXIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // No nesting: any request seen outside IDLE is lost and counted.
    if (interrupt_signal && (state_q != S_IDLE)) begin
      dropped_d = sat_inc(dropped_q);
    end

    // Outputs are registered, so they are derived from the state being entered.
    pending_d        = (state_d != S_IDLE);
    redirect_valid_d = (state_d == S_ENTER) || (state_d == S_EXIT);
    wr_enable_d      = (state_d == S_ENTER);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q           <= S_IDLE;
      vector_q          <= '0;
      pending_q         <= 1'b0;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
      mepc_q            <= '0;
      mcause_q          <= '0;
      wr_enable_q       <= 1'b0;
      dropped_q         <= '0;
    end else begin
      state_q           <= state_d;
      vector_q          <= vector_d;
      pending_q         <= pending_d;
      redirect_valid_q  <= redirect_valid_d;
      redirect_target_q <= redirect_target_d;
      mepc_q            <= mepc_d;
      mcause_q          <= mcause_d;
      wr_enable_q       <= wr_enable_d;
      dropped_q         <= dropped_d;
    end
  end

  assign interrupt_pending  = pending_q;
  assign pc_redirect_valid  = redirect_valid_q;
  assign pc_redirect_target = redirect_target_q;
  assign csr_mepc_out       = mepc_q;
  assign csr_mcause_out     = mcause_q;
  assign csr_wr_enable      = wr_enable_q;
  assign dropped_count      = dropped_q;

endmodule

// File: tb/tb_interrupt_trap_unit.sv
// Directed testbench for interrupt_trap_unit: a vector table covering entry,
// cause selection, mie gating and return, followed by hand-written sequences
// for counter saturation, the EXIT/IDLE pulse boundary and reset mid-handler.
module tb_interrupt_trap_unit;

  localparam logic [63:0] C_TMR = 64'h8000_0000_0000_0007;
  localparam logic [63:0] C_EXT = 64'h8000_0000_0000_000B;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        interrupt_signal;
  logic [63:0] interrupt_pc_in;
  logic        retire_valid_in;
  logic [63:0] retire_pc_next_in;
  logic        mret_in;
  logic        csr_mie_in;
  logic        interrupt_pending;
  logic        pc_redirect_valid;
  logic [63:0] pc_redirect_target;
  logic [63:0] csr_mepc_out;
  logic [63:0] csr_mcause_out;
  logic        csr_wr_enable;
  logic [7:0]  dropped_count;

  int checks = 0;
  int errors = 0;

  interrupt_trap_unit #(.TIMER_VECTOR(64'h1)) dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .interrupt_signal   (interrupt_signal),
    .interrupt_pc_in    (interrupt_pc_in),
    .retire_valid_in    (retire_valid_in),
    .retire_pc_next_in  (retire_pc_next_in),
    .mret_in            (mret_in),
    .csr_mie_in         (csr_mie_in),
    .interrupt_pending  (interrupt_pending),
    .pc_redirect_valid  (pc_redirect_valid),
    .pc_redirect_target (pc_redirect_target),
    .csr_mepc_out       (csr_mepc_out),
    .csr_mcause_out     (csr_mcause_out),
    .csr_wr_enable      (csr_wr_enable),
    .dropped_count      (dropped_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        sig;
    logic [63:0] pc;
    logic        ret;
    logic [63:0] npc;
    logic        mret;
    logic        mie;
    logic        pend;
    logic        rv;
    logic [63:0] tgt;
    logic        wr;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [7:0]  drop;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic sig, logic [63:0] pc, logic ret, logic [63:0] npc,
                              logic mret, logic mie, logic pend, logic rv,
                              logic [63:0] tgt, logic wr, logic [63:0] mepc,
                              logic [63:0] mcause, logic [7:0] drop);
    vec_t v;
    v.sig = sig; v.pc = pc; v.ret = ret; v.npc = npc; v.mret = mret; v.mie = mie;
    v.pend = pend; v.rv = rv; v.tgt = tgt; v.wr = wr; v.mepc = mepc;
    v.mcause = mcause; v.drop = drop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then let the rising edge
  // capture them; outputs are sampled 1 time unit after that edge.
  task automatic drive(input logic sig, input logic [63:0] pc, input logic ret,
                       input logic [63:0] npc, input logic mret, input logic mie);
    @(negedge clk_in);
    interrupt_signal  = sig;
    interrupt_pc_in   = pc;
    retire_valid_in   = ret;
    retire_pc_next_in = npc;
    mret_in           = mret;
    csr_mie_in        = mie;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_all(input string tag, input logic pend, input logic rv,
                         input logic [63:0] tgt, input logic wr, input logic [63:0] mepc,
                         input logic [63:0] mcause, input logic [7:0] drop);
    chk({tag, ".pending"}, {63'h0, interrupt_pending}, {63'h0, pend});
    chk({tag, ".redir_valid"}, {63'h0, pc_redirect_valid}, {63'h0, rv});
    chk({tag, ".redir_target"}, pc_redirect_target, tgt);
    chk({tag, ".wr_enable"}, {63'h0, csr_wr_enable}, {63'h0, wr});
    chk({tag, ".mepc"}, csr_mepc_out, mepc);
    chk({tag, ".mcause"}, csr_mcause_out, mcause);
    chk({tag, ".dropped"}, {56'h0, dropped_count}, {56'h0, drop});
  endtask

  initial begin
    //           sig  pc     ret  npc     mret mie  pend rv  tgt     wr  mepc    mcause drop
    // External vector 0x12, entry at the first boundary, then return.
    tbl[0]  = mk(1, 64'h12, 0, 64'h0,   0,   0,   1,   0,  64'h0,   0,  64'h0,   64'h0, 0);
    tbl[1]  = mk(0, 64'h0,  1, 64'h400, 0,   1,   1,   1,  64'h12,  1,  64'h400, C_EXT, 0);
    tbl[2]  = mk(0, 64'h0,  0, 64'h0,   0,   0,   1,   0,  64'h12,  0,  64'h400, C_EXT, 0);
    tbl[3]  = mk(0, 64'h0,  0, 64'h0,   1,   0,   1,   1,  64'h400, 0,  64'h400, C_EXT, 0);
    tbl[4]  = mk(0, 64'h0,  0, 64'h0,   0,   0,   0,   0,  64'h400, 0,  64'h400, C_EXT, 0);
    // Timer vector: retires with mie=0 (one with mret) are not boundaries, a
    // pulse while waiting is dropped, the boundary with mret is taken.
    tbl[5]  = mk(1, 64'h1,  0, 64'h0,   0,   0,   1,   0,  64'h400, 0,  64'h400, C_EXT, 0);
    tbl[6]  = mk(0, 64'h0,  1, 64'h500, 1,   0,   1,   0,  64'h400, 0,  64'h400, C_EXT, 0);
    tbl[7]  = mk(0, 64'h0,  1, 64'h504, 0,   0,   1,   0,  64'h400, 0,  64'h400, C_EXT, 0);
    tbl[8]  = mk(1, 64'h99, 0, 64'h0,   0,   1,   1,   0,  64'h400, 0,  64'h400, C_EXT, 1);
    tbl[9]  = mk(0, 64'h0,  1, 64'h508, 1,   1,   1,   1,  64'h1,   1,  64'h508, C_TMR, 1);
    tbl[10] = mk(0, 64'h0,  0, 64'h0,   0,   0,   1,   0,  64'h1,   0,  64'h508, C_TMR, 1);
    tbl[11] = mk(0, 64'h0,  1, 64'h600, 0,   1,   1,   0,  64'h1,   0,  64'h508, C_TMR, 1);
    tbl[12] = mk(0, 64'h0,  0, 64'h0,   1,   0,   1,   1,  64'h508, 0,  64'h508, C_TMR, 1);
    tbl[13] = mk(0, 64'h0,  0, 64'h0,   0,   0,   0,   0,  64'h508, 0,  64'h508, C_TMR, 1);

    reset_in          = 1'b1;
    interrupt_signal  = 1'b0;
    interrupt_pc_in   = '0;
    retire_valid_in   = 1'b0;
    retire_pc_next_in = '0;
    mret_in           = 1'b0;
    csr_mie_in        = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    chk_all("reset", 0, 0, 64'h0, 0, 64'h0, 64'h0, 8'd0);
    @(negedge clk_in);
    reset_in = 1'b0;
    idle_cycle();
    chk_all("post_reset", 0, 0, 64'h0, 0, 64'h0, 64'h0, 8'd0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].sig, tbl[i].pc, tbl[i].ret, tbl[i].npc, tbl[i].mret, tbl[i].mie);
      chk_all($sformatf("vec%0d", i), tbl[i].pend, tbl[i].rv, tbl[i].tgt, tbl[i].wr,
              tbl[i].mepc, tbl[i].mcause, tbl[i].drop);
    end

    // Enter a handler (vector 0x30, return 0x800) and flood it with pulses.
    drive(1'b1, 64'h30, 1'b0, 64'h0, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 64'h800, 1'b0, 1'b1);
    chk_all("sat_enter", 1, 1, 64'h30, 1, 64'h800, C_EXT, 8'd1);
    for (int i = 1; i <= 300; i++) begin
      drive(1'b1, 64'h77, 1'b0, 64'h0, 1'b0, 1'b0);
      if (i == 253) chk("sat_at_254", {56'h0, dropped_count}, 64'd254);
      if (i == 254) chk("sat_at_255", {56'h0, dropped_count}, 64'd255);
    end
    chk("sat_hold_255", {56'h0, dropped_count}, 64'd255);
    chk("sat_still_handler", {63'h0, interrupt_pending}, 64'd1);
    chk("sat_no_redirect", {63'h0, pc_redirect_valid}, 64'd0);

    // mret, then a pulse during EXIT (lost), then a pulse in the first IDLE cycle.
    drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk_all("exit", 1, 1, 64'h800, 0, 64'h800, C_EXT, 8'd255);
    drive(1'b1, 64'h44, 1'b0, 64'h0, 1'b0, 1'b0);
    chk_all("exit_pulse_dropped", 0, 0, 64'h800, 0, 64'h800, C_EXT, 8'd255);
    drive(1'b1, 64'h1, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("idle_pulse_accepted", {63'h0, interrupt_pending}, 64'd1);
    drive(1'b0, 64'h0, 1'b1, 64'h900, 1'b0, 1'b1);
    chk_all("idle_pulse_entry", 1, 1, 64'h1, 1, 64'h900, C_TMR, 8'd255);
    idle_cycle();
    chk("reset_pre_handler", {63'h0, interrupt_pending}, 64'd1);

    // Asynchronous reset in the middle of HANDLER.
    @(negedge clk_in);
    #2;
    reset_in = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 64'h0, 0, 64'h0, 64'h0, 8'd0);
    @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;
    idle_cycle();
    chk_all("after_reset_quiet", 0, 0, 64'h0, 0, 64'h0, 64'h0, 8'd0);
    idle_cycle();
    chk_all("after_reset_quiet2", 0, 0, 64'h0, 0, 64'h0, 64'h0, 8'd0);

    // Fresh entry after reset still works.
    drive(1'b1, 64'h20, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("reentry_pending", {63'h0, interrupt_pending}, 64'd1);
    drive(1'b0, 64'h0, 1'b1, 64'h700, 1'b0, 1'b1);
    chk_all("reentry", 1, 1, 64'h20, 1, 64'h700, C_EXT, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
